// File: rtl/div_pkg.sv
// Shared definitions for the divider sequencer: op encodings, FSM states,
// and counter sizing derived from the divider latency.
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

package div_pkg;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest width that holds latency-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned latency);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < latency) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Two-lane conditional two's-complement negate; used both to form operand
// magnitudes and to restore quotient/remainder signs.
module div_sign_fix
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = `DATA_BUS_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg_a,
  input  logic [WIDTH-1:0] b,
  input  logic             neg_b,
  output logic [WIDTH-1:0] fix_a,
  output logic [WIDTH-1:0] fix_b
);

  assign fix_a = neg_a ? (~a + 1'b1) : a;
  assign fix_b = neg_b ? (~b + 1'b1) : b;

endmodule

// File: rtl/div_ctrl.sv
// Multicycle sequencer for the combinational array divider (DIV/DIVU/REM/REMU).
// Optional DIV_RESULT_CACHE_EN reuses the last normally completed result.
module div_ctrl
  import div_pkg::*;
#(
  parameter int unsigned WIDTH       = `DATA_BUS_WIDTH,
  parameter int unsigned DIV_LATENCY = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   operand_1_i,
  input  logic [WIDTH-1:0]   operand_2_i,
  input  logic               flush_i,
  output logic               div_en_o,
  output logic [WIDTH-1:0]   div_op1_o,
  output logic [WIDTH-1:0]   div_op2_o,
  input  logic [2*WIDTH-1:0] div_result_i,
  output logic               stall_o,
  output logic               busy_o,
  output logic               result_valid_o,
  output logic [WIDTH-1:0]   result_o
);

  localparam int unsigned      CNT_W    = cnt_width(DIV_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic is_signed, is_rem, div_zero, overflow, special, hit, can_start;
  logic load_op, load_res, capture;
  logic [WIDTH-1:0] special_res, start_res, mag1, mag2, fix_quo, fix_rem;
  logic quo_neg, rem_neg, rem_sel;

  assign is_signed = ~op_i[0];
  assign is_rem    = op_i[1];
  assign div_zero  = (operand_2_i == '0);
  assign overflow  = is_signed && (operand_1_i == MIN_NEG) && (operand_2_i == '1);
  assign special   = div_zero | overflow;
  assign can_start = start_i && !flush_i && ((state == IDLE) || (state == DONE));

  always_comb begin
    special_res = '0;
    if (div_zero)    special_res = is_rem ? operand_1_i : '1;
    else if (!is_rem) special_res = MIN_NEG;
  end

  div_sign_fix #(.WIDTH(WIDTH)) u_pre (
    .a     (operand_1_i),
    .neg_a (is_signed & operand_1_i[WIDTH-1]),
    .b     (operand_2_i),
    .neg_b (is_signed & operand_2_i[WIDTH-1]),
    .fix_a (mag1),
    .fix_b (mag2)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_post (
    .a     (div_result_i[2*WIDTH-1:WIDTH]),
    .neg_a (quo_neg),
    .b     (div_result_i[WIDTH-1:0]),
    .neg_b (rem_neg),
    .fix_a (fix_quo),
    .fix_b (fix_rem)
  );

`ifdef DIV_RESULT_CACHE_EN
  logic             cache_valid, cache_sgn, req_sgn;
  logic [WIDTH-1:0] cache_op1, cache_op2, cache_quo, cache_rem, req_op1, req_op2;

  assign hit = cache_valid && (cache_op1 == operand_1_i) &&
               (cache_op2 == operand_2_i) && (cache_sgn == is_signed);
  assign start_res = special ? special_res : (is_rem ? cache_rem : cache_quo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid <= 1'b0;
      cache_sgn   <= 1'b0;
      cache_op1   <= '0;
      cache_op2   <= '0;
      cache_quo   <= '0;
      cache_rem   <= '0;
      req_sgn     <= 1'b0;
      req_op1     <= '0;
      req_op2     <= '0;
    end else begin
      if (load_op) begin
        req_sgn <= is_signed;
        req_op1 <= operand_1_i;
        req_op2 <= operand_2_i;
      end
      if (capture) begin
        cache_valid <= 1'b1;
        cache_sgn   <= req_sgn;
        cache_op1   <= req_op1;
        cache_op2   <= req_op2;
        cache_quo   <= fix_quo;
        cache_rem   <= fix_rem;
      end
    end
  end
`else
  assign hit       = 1'b0;
  assign start_res = special_res;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    div_en_o       = 1'b0;
    busy_o         = 1'b0;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    load_op        = 1'b0;
    load_res       = 1'b0;
    capture        = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        result_valid_o = (state == DONE) && !flush_i;
        state_nxt      = IDLE;
        if (can_start) begin
          stall_o = 1'b1;
          if (special || hit) begin
            load_res  = 1'b1;
            state_nxt = DONE;
          end else begin
            load_op   = 1'b1;
            cnt_nxt   = CNT_LOAD;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        busy_o   = 1'b1;
        div_en_o = !flush_i;
        stall_o  = !flush_i;
        if (cnt == '0) begin
          capture   = !flush_i;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_op1_o <= '0;
      div_op2_o <= '0;
      quo_neg   <= 1'b0;
      rem_neg   <= 1'b0;
      rem_sel   <= 1'b0;
      result_o  <= '0;
    end else begin
      if (load_op) begin
        div_op1_o <= mag1;
        div_op2_o <= mag2;
        quo_neg   <= is_signed & (operand_1_i[WIDTH-1] ^ operand_2_i[WIDTH-1]);
        rem_neg   <= is_signed & operand_1_i[WIDTH-1];
        rem_sel   <= is_rem;
      end
      if (load_res) result_o <= start_res;
      else if (capture) result_o <= rem_sel ? fix_rem : fix_quo;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized self-checking bench for div_ctrl against a cycle-level behavioural
// model; honours DIV_RESULT_CACHE_EN when defined for the build.
module tb_div_ctrl;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 4;
`ifdef DIV_RESULT_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam int HIT_LAT = CACHE ? 1 : LAT + 1;
  localparam logic [W-1:0] MINV = 32'h8000_0000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start_i = 1'b0;
  logic           flush_i = 1'b0;
  logic [1:0]     op_i = 2'd0;
  logic [W-1:0]   operand_1_i = '0;
  logic [W-1:0]   operand_2_i = '0;
  logic           div_en_o, stall_o, busy_o, result_valid_o;
  logic [W-1:0]   div_op1_o, div_op2_o, result_o;
  logic [2*W-1:0] div_result_i;
  logic [2*W-1:0] junk = '0;

  div_ctrl #(.WIDTH(W), .DIV_LATENCY(LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .op_i           (op_i),
    .operand_1_i    (operand_1_i),
    .operand_2_i    (operand_2_i),
    .flush_i        (flush_i),
    .div_en_o       (div_en_o),
    .div_op1_o      (div_op1_o),
    .div_op2_o      (div_op2_o),
    .div_result_i   (div_result_i),
    .stall_o        (stall_o),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o)
  );

  always #5 clk = ~clk;

  // Array divider stand-in: garbage whenever the sequencer is not enabling it.
  always_comb begin
    if (div_en_o && div_op2_o != '0) div_result_i = {div_op1_o / div_op2_o, div_op1_o % div_op2_o};
    else div_result_i = junk;
  end

  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic sgn;
    logic rem;
    sgn = (op == 2'd0) || (op == 2'd2);
    rem = op[1];
    if (b == '0) return rem ? a : '1;
    if (sgn) begin
      if (a == MINV && b == '1) return rem ? '0 : MINV;
      return rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    end
    return rem ? a % b : a / b;
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) || (((op == 2'd0) || (op == 2'd2)) && a == MINV && b == '1);
  endfunction

  function automatic logic [W-1:0] mag(input logic [W-1:0] a, input bit sgn);
    return (sgn && a[W-1]) ? -a : a;
  endfunction

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;

  int           m_wait = 0;
  bit           m_done = 0;
  logic [W-1:0] m_last = '0, m_pend = '0, m_mag1 = '0, m_mag2 = '0;
  bit           c_valid = 0, c_sgn = 0, p_sgn = 0;
  logic [W-1:0] c_a = '0, c_b = '0, p_a = '0, p_b = '0;
  bit           t_on = 0;
  logic [W-1:0] t_val = '0;
  int           t_lat = 0, t_acc = 0;
  bit           s_lit_on = 0;
  logic [W-1:0] s_lit_val = '0;
  int           s_lit_lat = 0;
  bit           waiting, acc, sgn_now, hit_now;
  logic [W-1:0] res_now;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      check("rst_div_en", div_en_o, 0);
      check("rst_stall", stall_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_valid", result_valid_o, 0);
      check("rst_result", result_o, 0);
      check("rst_op1", div_op1_o, 0);
      check("rst_op2", div_op2_o, 0);
      m_wait = 0; m_done = 0; m_last = '0; c_valid = 0; t_on = 0;
    end else begin
      waiting = (m_wait > 0);
      acc     = !waiting && start_i && !flush_i;
      check("div_en", div_en_o, waiting && !flush_i);
      check("busy", busy_o, waiting);
      check("stall", stall_o, !flush_i && (acc || waiting));
      check("valid", result_valid_o, m_done && !flush_i);
      check("result", result_o, m_last);
      if (waiting) begin
        check("div_op1", div_op1_o, m_mag1);
        check("div_op2", div_op2_o, m_mag2);
      end
      if (m_done && !flush_i && t_on) begin
        check("lit_result", result_o, t_val);
        check("lit_model", m_last, t_val);
        check("lit_latency", cyc - t_acc, t_lat);
        t_on = 0;
      end
      if (flush_i) begin
        m_wait = 0; m_done = 0; t_on = 0;
      end else if (waiting) begin
        m_done = 0;
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          m_done = 1; m_last = m_pend;
          c_valid = 1; c_a = p_a; c_b = p_b; c_sgn = p_sgn;
        end
      end else begin
        m_done = 0;
        if (acc) begin
          sgn_now = !op_i[0];
          res_now = ref_result(op_i, operand_1_i, operand_2_i);
          hit_now = CACHE && c_valid && c_a == operand_1_i && c_b == operand_2_i && c_sgn == sgn_now;
          t_on = s_lit_on; t_val = s_lit_val; t_lat = s_lit_lat; t_acc = cyc;
          if (is_special(op_i, operand_1_i, operand_2_i) || hit_now) begin
            m_done = 1; m_last = res_now;
          end else begin
            m_wait = LAT; m_pend = res_now;
            m_mag1 = mag(operand_1_i, sgn_now); m_mag2 = mag(operand_2_i, sgn_now);
            p_a = operand_1_i; p_b = operand_2_i; p_sgn = sgn_now;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    junk = {$urandom, $urandom};
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit lit, input logic [W-1:0] v, input int lat);
    op_i = op; operand_1_i = a; operand_2_i = b; start_i = 1'b1;
    s_lit_on = lit; s_lit_val = v; s_lit_lat = lat;
    step();
    start_i = 1'b0; s_lit_on = 0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40 && (m_wait > 0 || m_done); n++) step();
  endtask

  task automatic wait_done();
    for (int n = 0; n < 40 && !m_done; n++) step();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return MINV;
      4: return W'($urandom_range(0, 20));
      5: return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    issue(2'd1, 32'd100, 32'd7, 1, 32'd14, LAT + 1);               wait_idle();
    issue(2'd0, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, LAT + 1);  wait_idle();
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, HIT_LAT);  wait_idle();
    issue(2'd1, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 1);                wait_idle();
    issue(2'd3, 32'd5, 32'd0, 1, 32'd5, 1);                        wait_idle();
    issue(2'd0, MINV, 32'hFFFF_FFFF, 1, MINV, 1);                  wait_idle();
    issue(2'd2, MINV, 32'hFFFF_FFFF, 1, 32'd0, 1);                 wait_idle();

    issue(2'd1, 32'd101, 32'd7, 0, '0, 0);
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    issue(2'd1, 32'd200, 32'd9, 1, 32'd22, LAT + 1);               wait_idle();

    issue(2'd0, 32'd100, 32'd7, 1, 32'd14, LAT + 1);               wait_done();
    issue(2'd2, 32'd100, 32'd7, 1, 32'd2, HIT_LAT);                wait_idle();

    issue(2'd1, 32'd1000, 32'd3, 0, '0, 0);
    #2 rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 3000; i++) begin
      flush_i = ($urandom_range(0, 19) == 0);
      start_i = ($urandom_range(0, 2) == 0);
      op_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        operand_1_i = pick();
        operand_2_i = pick();
      end
      if (i == 1500) begin
        start_i = 1'b0; flush_i = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      step();
    end
    start_i = 1'b0; flush_i = 1'b0;
    for (int i = 0; i < 10; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Multi-cycle sequencer that sits in the EX stage between the instruction datapath and the combinational array Divider.
- Accepts RISC-V DIV/DIVU/REM/REMU requests.
- Converts signed operands to magnitudes and holds them stable on the Divider inputs for DIV_LATENCY cycles (multicycle path).
- Captures {quo, rem}, applies sign fix-up, and resolves divide-by-zero and overflow without using the array.
- Stalls the pipeline while busy.

Parameters:
- WIDTH, `DATA_BUS_WIDTH (32), operand/result width.
- DIV_LATENCY, 4, cycles the registered operands are held before the array output is sampled; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous assert, active-low; clk and rst_n form the block's single clock/reset pair.
- start_i  in  1  request strobe, sampled only in IDLE or DONE.
- op_i  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU.
- operand_1_i  in  WIDTH  dividend.
- operand_2_i  in  WIDTH  divisor.
- flush_i  in  1  pipeline flush; aborts any operation.
- div_en_o  out  1  drives Divider div_en.
- div_op1_o  out  WIDTH  unsigned dividend magnitude to Divider.
- div_op2_o  out  WIDTH  unsigned divisor magnitude to Divider.
- div_result_i  in  2*WIDTH  Divider result; quotient in [2W-1:W], remainder in [W-1:0].
- stall_o  out  1  pipeline stall request.
- busy_o  out  1  high in WAIT.
- result_valid_o  out  1  one-cycle result pulse.
- result_o  out  WIDTH  selected quotient or remainder.

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0.
- States:
  - IDLE: on start_i && !flush_i:
    - divisor==0 or overflow → DONE next cycle with the special result.
    - Otherwise register magnitudes, signs, op; load counter = DIV_LATENCY-1; → WAIT.
  - WAIT: div_en_o=1; operand outputs constant. When counter==0, capture div_result_i, apply fix-up, register result_o → DONE. Otherwise decrement the counter.
  - DONE: result_valid_o=1 for exactly this cycle; result_o held until the next capture. start_i is accepted here with the same rules as IDLE (back-to-back requests), otherwise → IDLE.
- Latency: normal op start accepted at cycle 0 → result_valid_o at cycle DIV_LATENCY+1. Special cases → cycle 1.
- stall_o = (start_i accepted this cycle) OR state==WAIT. It is combinational so the issuing instruction holds until valid.
- Signed ops (DIV, REM):
  - magnitude = two's-complement negate if MSB set.
  - Quotient negated when operand signs differ.
  - Remainder takes the dividend's sign.
- Unsigned ops: operands are passed unchanged.
- Divide by zero: quotient = all ones; remainder = operand_1_i (unmodified, signed or unsigned).
- Overflow (DIV/REM, operand_1=0x80..0, operand_2=all ones): quotient = 0x80..0, remainder = 0.
- Flush: flush_i in any state → IDLE next cycle, no result_valid_o, div_en_o low, stall_o low that cycle. Flush coincident with start_i: flush wins, the request is dropped.
- start_i while in WAIT is ignored; the upstream stall guarantees it cannot occur legally.
- Reset mid-operation: immediate return to IDLE, outputs 0.

Optional Feature:
DIV_RESULT_CACHE_EN
- Defined:
  - Keep a valid bit plus last operand_1, operand_2, signedness, and the fixed-up quotient and remainder from the last normally completed (non-special, non-flushed) op.
  - A start whose operands and signedness match skips WAIT → DONE next cycle, selecting quotient or remainder per op_i.
  - The valid bit is cleared by reset only.
- Undefined: no storage; every op takes the full latency.

Decomposition:
- Package div_pkg: op encoding constants (DIV/DIVU/REM/REMU), state enum (IDLE/WAIT/DONE), counter width derived from DIV_LATENCY.
- One sub-module, div_sign_fix: combinational operand-magnitude and result sign fix-up, instantiated twice (pre and post).

Test Plan:
- DIVU 100/7, DIV_LATENCY=4 → result_valid_o at cycle 5, result_o=14; stall_o high cycles 0-4.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF (remainder is -1).
- DIVU 5/0 → 0xFFFFFFFF at cycle 1; REMU 5/0 → 5; div_en_o never asserted.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; both at cycle 1.
- DIVU 100/7 with flush_i at cycle 2 → no result_valid_o, IDLE at cycle 3; a new start at cycle 3 completes normally.
- With DIV_RESULT_CACHE_EN: DIV 100/7 followed by REM 100/7 in the DONE cycle → second result 2 valid one cycle later. Without the macro → the second result arrives after the full latency.
